// File: rtl/dmem_pkg.sv
// Shared types for the dmem_responder slice: access-size encodings, FSM states
// and the size-to-byte-count helper.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering for an aligned 8-byte little-endian window:
// load extraction/extension and store byte-enable/data placement.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [63:0] window,
  input  logic [2:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [63:0] wdata,
  output logic [63:0] rdata,
  output logic [7:0]  byte_en,
  output logic [63:0] wdata_lanes
);

  logic [63:0] shifted;
  logic [8:0]  lane_mask;

  always_comb begin
    shifted     = window >> {offset, 3'b000};
    rdata       = shifted;
    case (size_e'(size))
      SZ_B:    rdata = is_unsigned ? {56'b0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
      SZ_H:    rdata = is_unsigned ? {48'b0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      SZ_W:    rdata = is_unsigned ? {32'b0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      default: rdata = shifted;
    endcase
    lane_mask   = (9'd1 << size_bytes(size)) - 9'd1;
    byte_en     = lane_mask[7:0] << offset;
    wdata_lanes = wdata << {offset, 3'b000};
  end

endmodule

// File: rtl/dmem_responder.sv
// Handshaked fixed-latency byte-addressable data memory for the MEM stage.
// Define DMEM_RESPONDER_STATS_EN to add saturating load/store/error counters.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = 512,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  output logic [63:0] rsp_rdata,
  output logic        rsp_error,
  output logic        busy
`ifdef DMEM_RESPONDER_STATS_EN
  ,
  output logic [31:0] stat_loads,
  output logic [31:0] stat_stores,
  output logic [31:0] stat_errors
`endif
);

  localparam int unsigned AW = $clog2(DEPTH_BYTES);
  localparam int unsigned CW = $clog2(LATENCY + 1);

  state_e         state, state_next;
  logic           accept;
  logic [CW-1:0]  cnt;

  logic           lat_write, lat_unsigned;
  logic [1:0]     lat_size;
  logic [63:0]    lat_addr, lat_wdata;

  logic           cur_write, cur_unsigned;
  logic [1:0]     cur_size;
  logic [63:0]    cur_addr, cur_wdata;

  logic [7:0]     mem [DEPTH_BYTES];
  logic [AW-1:0]  base;
  logic [63:0]    window, rdata, wdata_lanes;
  logic [7:0]     byte_en;
  logic [3:0]     nbytes;
  logic [2:0]     align_mask;
  logic           misaligned, out_of_range, err, commit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: if (req_valid) begin
        accept     = 1'b1;
        state_next = (LATENCY > 1) ? WAIT : RESP;
      end
      WAIT:    if (cnt == CW'(1)) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    req_ready = (state == IDLE);
    busy      = (state != IDLE);
    rsp_valid = (state == RESP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt          <= '0;
      lat_write    <= 1'b0;
      lat_unsigned <= 1'b0;
      lat_size     <= '0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
    end else if (accept) begin
      cnt          <= CW'(LATENCY - 1);
      lat_write    <= req_write;
      lat_unsigned <= req_unsigned;
      lat_size     <= req_size;
      lat_addr     <= req_addr;
      lat_wdata    <= req_wdata;
    end else if (state == WAIT) begin
      cnt          <= cnt - CW'(1);
    end
  end

  // With LATENCY==1 the accept edge is also the commit edge, so the fields
  // are taken straight from the request instead of the latches.
  always_comb begin
    if (state == IDLE) begin
      cur_write    = req_write;
      cur_unsigned = req_unsigned;
      cur_size     = req_size;
      cur_addr     = req_addr;
      cur_wdata    = req_wdata;
    end else begin
      cur_write    = lat_write;
      cur_unsigned = lat_unsigned;
      cur_size     = lat_size;
      cur_addr     = lat_addr;
      cur_wdata    = lat_wdata;
    end
  end

  always_comb begin
    nbytes       = size_bytes(cur_size);
    align_mask   = 3'(nbytes - 4'd1);
    misaligned   = |(cur_addr[2:0] & align_mask);
    out_of_range = (|cur_addr[63:AW]) ||
                   (({1'b0, cur_addr[AW-1:0]} + (AW+1)'(nbytes)) > (AW+1)'(DEPTH_BYTES));
    err          = misaligned || out_of_range;
    commit       = (state_next == RESP) && !reset;
    base         = cur_addr[AW-1:0] & ~AW'(7);
    window       = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      window[8*k +: 8] = mem[base | AW'(k)];
    end
  end

  dmem_lane_align u_lane_align (
    .window      (window),
    .offset      (cur_addr[2:0]),
    .size        (cur_size),
    .is_unsigned (cur_unsigned),
    .wdata       (cur_wdata),
    .rdata       (rdata),
    .byte_en     (byte_en),
    .wdata_lanes (wdata_lanes)
  );

  always_ff @(posedge clk) begin
    if (commit && cur_write && !err) begin
      for (int unsigned k = 0; k < 8; k++) begin
        if (byte_en[k]) mem[base | AW'(k)] <= wdata_lanes[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
    end else if (commit) begin
      rsp_rdata <= (!cur_write && !err) ? rdata : '0;
      rsp_error <= err;
    end
  end

`ifdef DMEM_RESPONDER_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_loads  <= '0;
      stat_stores <= '0;
      stat_errors <= '0;
    end else if (state == RESP) begin
      if (rsp_error) begin
        if (stat_errors != '1) stat_errors <= stat_errors + 32'd1;
      end else if (lat_write) begin
        if (stat_stores != '1) stat_stores <= stat_stores + 32'd1;
      end else begin
        if (stat_loads != '1) stat_loads <= stat_loads + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder at the far end of the load/store port driven by the processor's MEM stage. It replaces the single-cycle combinational data memory with a handshaked, fixed-latency, byte-addressable memory. It supports byte/half/word/double access with sign or zero extension and reports misaligned or out-of-range accesses. The MEM stage stalls on `req_ready`/`rsp_valid`.

Parameters:
- DEPTH_BYTES, 512, memory size in bytes; power of two, >= 8.
- LATENCY, 2, cycles from request acceptance to response; >= 1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present; initiator holds all req_* stable until accepted.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 double.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  64  byte address.
- req_wdata  in  64  store data; low 8·2^size bits are used.
- rsp_valid  out  1  one-cycle pulse: response ready.
- rsp_rdata  out  64  load result; holds until the next response.
- rsp_error  out  1  qualifies rsp_valid: misaligned or out-of-range access.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset values: state IDLE, req_ready=1 (combinational from IDLE), rsp_valid=0, rsp_rdata=0, rsp_error=0, busy=0, wait counter=0. Memory contents are not affected by reset.
- FSM states:
  - IDLE: on req_valid, accept at edge T. Latch all req_* fields. Counter := LATENCY-1. Go to WAIT if LATENCY>1, else go directly to RESP.
  - WAIT: decrement the counter each cycle. When counter==1, go to RESP.
  - RESP: rsp_valid=1 for exactly this cycle, then IDLE.
- Timing: the request is accepted at edge T. RESP occupies cycle T+LATENCY. The next request can be accepted at edge T+LATENCY+1, so throughput is one access per LATENCY+1 cycles.
- Commit point: the edge entering RESP.
  - A store writes memory at the commit edge.
  - A load samples memory at the commit edge into rsp_rdata.
  - A load immediately following a store to the same address returns the new data.
- Endianness: little-endian. Byte k of the access is at address addr+k.
- Load extension: the loaded value is extended to 64 bits per req_unsigned. A double ignores req_unsigned.
- Store rsp_rdata: for a store, rsp_rdata=0.
- Error rule: rsp_error=1 if the address is misaligned (addr mod 2^size != 0) or addr+2^size > DEPTH_BYTES.
  - On error: no memory write, rsp_rdata=0.
  - The FSM timing is the same as for a normal access.
- Flow control: req_valid while busy is ignored, with no queueing. There is no response backpressure; the initiator must capture rsp_valid.
- Reset mid-operation: the access is aborted.
  - If reset arrives before the commit edge, memory is unchanged and no rsp_valid is produced.
  - If reset arrives during RESP, rsp_valid drops immediately (asynchronous reset).
- Unused address bits: bits above log2(DEPTH_BYTES) must be zero, otherwise the access is out-of-range.

Optional Feature:
- Macro: DMEM_RESPONDER_STATS_EN.
- With the macro defined: adds outputs stat_loads, stat_stores, stat_errors (each 32 bits).
  - Each counter increments on the RESP cycle of the matching access.
  - Error accesses count only in stat_errors.
  - Counters saturate at 0xFFFFFFFF and reset asynchronously to 0.
- Without the macro: these ports and counters do not exist.

Decomposition:
- Package dmem_pkg:
  - size encodings SZ_B/SZ_H/SZ_W/SZ_D.
  - FSM state enum IDLE/WAIT/RESP.
  - function size_bytes(size).
- Sub-module dmem_lane_align: combinational. It extracts and extends load bytes from a 64-bit little-endian window, and generates the store byte-enable mask plus shifted write data.
- Top level holds the FSM, the latches and the memory array.

Test Plan:
1. Reset then idle → req_ready=1, rsp_valid=0, rsp_rdata=0, busy=0.
2. Store double 0x1122334455667788 @0x10, then load double @0x10 (LATENCY=2) → each rsp_valid exactly 2 cycles after acceptance; load returns 0x1122334455667788; req_ready low for 2 cycles per access.
3. After test 2, byte/half/word loads @0x10:
   - Signed byte @0x17 → 0x0000000000000011.
   - Store byte 0x80 @0x18, then signed byte @0x18 → 0xFFFFFFFFFFFFFF80; unsigned → 0x80.
   - Signed half @0x16 → 0x1122.
4. Misaligned word load @0x12 and store @0x200 (DEPTH_BYTES=512) → rsp_error=1, rsp_rdata=0; memory at 0x1FC..0x1FF unchanged on readback.
5. Assert reset in the WAIT cycle of a store 0xAA @0x20 → no rsp_valid; a later byte load @0x20 returns the prior content.
6. With DMEM_RESPONDER_STATS_EN: 3 loads, 2 stores, 1 error → stat_loads=3, stat_stores=2, stat_errors=1.
